ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester arbiter that shares the single port of the console's synchronous work RAM between the CPU and the video scanout engine. It sits directly upstream of the synchronous RAM and drives its address, write-data and write-enable inputs. It consumes the RAM's one-cycle-latency read data and returns it to whichever requester issued the read. The block is fully pipelined, so it sustains one access per clock.

## Interface
- `A`, default 10, address width in bits; must match the RAM.
- `D`, default 8, data width in bits; must match the RAM.

Ports (name, direction, width, meaning):
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: CPU write (1) or read (0).
- `cpu_addr` in A: CPU address.
- `cpu_wdata` in D: CPU write data.
- `cpu_gnt` out 1: CPU request accepted this cycle (combinational).
- `cpu_rvalid` out 1: CPU read data valid (registered pulse).
- `cpu_rdata` out D: CPU read data.
- `vid_req` in 1: video read request (video never writes).
- `vid_addr` in A: video address.
- `vid_gnt` out 1: video request accepted this cycle (combinational).
- `vid_rvalid` out 1: video read data valid.
- `vid_rdata` out D: video read data.
- `ram_addr` out A: address to the RAM.
- `ram_din` out D: write data to the RAM.
- `ram_we` out 1: write enable to the RAM.
- `ram_dout` in D: RAM read data, valid one cycle after the address is sampled.

## Operation
- Each cycle, at most one requester is granted. A grant is the handshake: a requester holds its `req`, `addr`, `we` and `wdata` stable until its `gnt` is high. In the cycle after a grant, it may present a new transaction or drop `req`.
- Granted CPU access:
  - `ram_addr = cpu_addr`
  - `ram_din = cpu_wdata`
  - `ram_we = cpu_we`
- Granted video access:
  - `ram_addr = vid_addr`
  - `ram_we = 0`
  - `ram_din = cpu_wdata` (don't-care)
- No grant: `ram_we = 0`, `ram_addr = cpu_addr`.
- Arbitration, default: video has fixed priority. `cpu_gnt = cpu_req & ~vid_req`.
- A read granted in cycle G produces `xx_rvalid = 1` in cycle G+1, with `xx_rdata = ram_dout`.
- `xx_rdata` holds the last returned value until that port's next `rvalid`.
- Writes never produce `rvalid` and never change `rdata`.
- State:
  - the `cpu_rvalid` and `vid_rvalid` flops;
  - one D-bit hold register per port, loaded on its `rvalid` cycle;
  - `last_gnt` (1 = video), used by the fair option.

## Timing
- Reset values:
  - `cpu_rvalid = vid_rvalid = 0`
  - `cpu_rdata = vid_rdata = 0`
  - `last_gnt = 0` (CPU)
- While `rst_n` is low: `cpu_gnt`, `vid_gnt` and `ram_we` are forced to 0.
- Read latency is exactly 1 cycle from grant to `rvalid`. Throughput is 1 access per cycle, so back-to-back grants to the same or alternating ports are legal.
- Write followed by a read of the same address in the next cycle returns the new data, because the RAM has completed the write by then.
- Same-cycle read and write cannot occur: there is a single grant per cycle.
- Reset asserted while an `rvalid` is pending: `rvalid` is cleared immediately and no data is returned after reset releases.
- `req` low: no grant, regardless of the other signals.
- Address wrap is not handled here; addresses are passed through unchanged.

## Configuration
- `ARB_FAIR_EN` defined: when both ports request in the same cycle, grant the port not equal to `last_gnt`. `last_gnt` updates on every grant. A lone requester is always granted immediately.
- `ARB_FAIR_EN` undefined: fixed video priority. `last_gnt` is not implemented, and the CPU can be stalled indefinitely by continuous `vid_req`.

## Test plan
- Reset: hold `rst_n` low with both `req` high.
  - Required: all `gnt`, `rvalid`, `ram_we` and `rdata` equal 0.
  - Release reset: `vid_gnt = 1` in the first active cycle.
- CPU write then read:
  - Write `0x155 <- 0xA5` (`cpu_gnt = 1`, `ram_we = 1`, no `rvalid`).
  - Next cycle, read `0x155`: `cpu_rvalid = 1` one cycle later with `cpu_rdata = 0xA5`, held until the next CPU read.
- Video burst: `vid_req` high for 3 cycles with addresses 0, 1, 2 (preloaded 0x10, 0x11, 0x12).
  - Required: `vid_gnt` high for 3 cycles.
  - `vid_rvalid` high for the next 3 cycles with data 0x10, 0x11, 0x12.
- Contention, default build: both request for 4 cycles.
  - Required: `vid_gnt = 1`, `cpu_gnt = 0` every cycle.
  - CPU granted in the first cycle `vid_req` drops.
- Contention with `ARB_FAIR_EN`: both request for 4 cycles from reset.
  - Required: grants alternate video, CPU, video, CPU.
  - `rvalid` pulses alternate port accordingly.
- Reset mid-operation: pull `rst_n` low in the cycle after a CPU read grant.
  - Required: `cpu_rvalid` never asserts and `cpu_rdata = 0`.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous RAM port between the CPU and
// the video scanout engine. It sustains one access per clock, and read data
// returns one cycle after the grant.
// Optional build macro ARB_FAIR_EN: when both ports request in the same
// cycle, the grants alternate between them. When the macro is undefined,
// video has fixed priority.
module ram_port_arbiter #(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [A-1:0] cpu_addr,
  input  logic [D-1:0] cpu_wdata,
  output logic         cpu_gnt,
  output logic         cpu_rvalid,
  output logic [D-1:0] cpu_rdata,
  input  logic         vid_req,
  input  logic [A-1:0] vid_addr,
  output logic         vid_gnt,
  output logic         vid_rvalid,
  output logic [D-1:0] vid_rdata,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout
);

  logic         cpu_rvalid_q;
  logic         vid_rvalid_q;
  logic [D-1:0] cpu_hold_q;
  logic [D-1:0] vid_hold_q;

`ifdef ARB_FAIR_EN
  logic last_gnt_q;  // 1 = video was granted most recently

  // Grant selection: a lone requester always wins; on a tie, the port not granted last time wins.
  always_comb begin
    vid_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (rst_n) begin
      vid_gnt = vid_req & (~cpu_req | ~last_gnt_q);
      cpu_gnt = cpu_req & (~vid_req |  last_gnt_q);
    end
  end

  // Track which port received the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_gnt_q <= 1'b0;
    else if (vid_gnt) last_gnt_q <= 1'b1;
    else if (cpu_gnt) last_gnt_q <= 1'b0;
  end
`else
  // Grant selection: video has fixed priority over the CPU.
  always_comb begin
    vid_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (rst_n) begin
      vid_gnt = vid_req;
      cpu_gnt = cpu_req & ~vid_req;
    end
  end
`endif

  // RAM port mux: the CPU address is the idle default, and only a CPU write drives the write enable.
  always_comb begin
    ram_addr = vid_gnt ? vid_addr : cpu_addr;
    ram_din  = cpu_wdata;
    ram_we   = cpu_gnt & cpu_we;
  end

  // Read-return tracking: a read granted this cycle raises rvalid in the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      vid_rvalid_q <= vid_gnt;
    end
  end

  // Hold registers capture the returned data so it persists after the rvalid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_hold_q <= '0;
      vid_hold_q <= '0;
    end else begin
      if (cpu_rvalid_q) cpu_hold_q <= ram_dout;
      if (vid_rvalid_q) vid_hold_q <= ram_dout;
    end
  end

  // Read data output: pass the live RAM output during rvalid, otherwise present the held value.
  always_comb begin
    cpu_rvalid = cpu_rvalid_q;
    vid_rvalid = vid_rvalid_q;
    cpu_rdata  = cpu_rvalid_q ? ram_dout : cpu_hold_q;
    vid_rdata  = vid_rvalid_q ? ram_dout : vid_hold_q;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter. It models the synchronous RAM locally.
// Expected read returns are queued when a grant is observed, and a monitor
// pops and compares them on each rvalid.
module tb_ram_port_arbiter;
  localparam int A = 10;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we;
  logic [A-1:0] cpu_addr;
  logic [D-1:0] cpu_wdata;
  logic         cpu_gnt, cpu_rvalid;
  logic [D-1:0] cpu_rdata;
  logic         vid_req;
  logic [A-1:0] vid_addr;
  logic         vid_gnt, vid_rvalid;
  logic [D-1:0] vid_rdata;
  logic [A-1:0] ram_addr;
  logic [D-1:0] ram_din;
  logic         ram_we;
  logic [D-1:0] ram_dout;

  logic [D-1:0] mem [0:(1<<A)-1];

  int tests = 0;
  int fails = 0;
  logic [D-1:0] cpu_q[$];
  logic [D-1:0] vid_q[$];

  ram_port_arbiter #(.A(A), .D(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an expected entry queued in the previous cycle must be consumed by rvalid now.
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
      else chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
    end else if (cpu_q.size() != 0) begin
      chk("cpu_rvalid_missing", 32'(cpu_rvalid), 32'd1);
      cpu_q.delete();
    end
    if (vid_rvalid) begin
      if (vid_q.size() == 0) chk("vid_rvalid_unexpected", 32'(vid_rvalid), 32'd0);
      else chk("vid_rdata", 32'(vid_rdata), 32'(vid_q.pop_front()));
    end else if (vid_q.size() != 0) begin
      chk("vid_rvalid_missing", 32'(vid_rvalid), 32'd1);
      vid_q.delete();
    end
  end

  initial begin
    logic vexp;
    for (int i = 0; i < (1 << A); i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155; cpu_wdata = 8'h00;
    vid_req = 1'b1; vid_addr = '0;

    // Reset with both ports requesting.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_vid_gnt", 32'(vid_gnt), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_vid_rvalid", 32'(vid_rvalid), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_vid_rdata", 32'(vid_rdata), 0);

    // First active cycle: video is granted.
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_vid_gnt", 32'(vid_gnt), 1);
    chk("rel_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rel_ram_addr", 32'(ram_addr), 32'h000);
    vid_q.push_back(8'h10);

    // No requests: no grant, no write, and the CPU address is passed through.
    @(negedge clk); cpu_req = 1'b0; vid_req = 1'b0; cpu_we = 1'b1; cpu_addr = 10'h2AA; #1;
    chk("idle_cpu_gnt", 32'(cpu_gnt), 0);
    chk("idle_vid_gnt", 32'(vid_gnt), 0);
    chk("idle_ram_we", 32'(ram_we), 0);
    chk("idle_ram_addr", 32'(ram_addr), 32'h2AA);

    // CPU writes 0x155 <- 0xA5, then reads it back in the next cycle.
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h155; cpu_wdata = 8'hA5; #1;
    chk("wr_cpu_gnt", 32'(cpu_gnt), 1);
    chk("wr_ram_we", 32'(ram_we), 1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h155);
    chk("wr_ram_din", 32'(ram_din), 32'hA5);
    @(negedge clk); cpu_we = 1'b0; cpu_wdata = 8'h00; #1;
    chk("rd_cpu_gnt", 32'(cpu_gnt), 1);
    chk("rd_ram_we", 32'(ram_we), 0);
    cpu_q.push_back(8'hA5);
    @(negedge clk); cpu_req = 1'b0;
    @(negedge clk); #1;
    chk("cpu_rdata_hold", 32'(cpu_rdata), 32'hA5);
    chk("vid_rdata_hold", 32'(vid_rdata), 32'h10);

    // Video burst of three reads at addresses 0, 1 and 2.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); vid_req = 1'b1; vid_addr = 10'(i); #1;
      chk("burst_vid_gnt", 32'(vid_gnt), 1);
      chk("burst_ram_addr", 32'(ram_addr), 32'(i));
      vid_q.push_back(8'(8'h10 + i));
    end
    @(negedge clk); vid_req = 1'b0;
    @(negedge clk); #1;
    chk("burst_vid_hold", 32'(vid_rdata), 32'h12);
    chk("burst_cpu_hold", 32'(cpu_rdata), 32'hA5);

    // Contention from reset: both ports request for four cycles.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
    vid_req = 1'b1; vid_addr = 10'h003;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef ARB_FAIR_EN
      vexp = (k % 2 == 0);
`else
      vexp = 1'b1;
`endif
      chk("cont_vid_gnt", 32'(vid_gnt), 32'(vexp));
      chk("cont_cpu_gnt", 32'(cpu_gnt), 32'(!vexp));
      if (vexp) vid_q.push_back(8'(8'h10 + vid_addr));
      else      cpu_q.push_back(8'hA5);
      @(negedge clk);
      if (vexp) vid_addr = vid_addr + 10'd1;
    end
    vid_req = 1'b0; #1;
    chk("cont_cpu_after", 32'(cpu_gnt), 1);
    cpu_q.push_back(8'hA5);
    @(negedge clk); cpu_req = 1'b0;
    @(negedge clk); #1;
    chk("cont_cpu_hold", 32'(cpu_rdata), 32'hA5);

    // Reset asserted while a CPU read return is pending.
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155; #1;
    chk("mid_cpu_gnt", 32'(cpu_gnt), 1);
    @(posedge clk); #1; rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk); #1;
    chk("mid_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("mid_cpu_rdata", 32'(cpu_rdata), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_cpu_rdata", 32'(cpu_rdata), 0);
    chk("post_cpu_rvalid", 32'(cpu_rvalid), 0);

    @(negedge clk); #1;
    chk("cpu_q_drained", 32'(cpu_q.size()), 0);
    chk("vid_q_drained", 32'(vid_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
